// File: rtl/fifo_frame_pkg.sv
// Shared definitions for the FIFO frame writer and the read-side frame checker.
package fifo_frame_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_MAX_LEN    = 16;
  localparam int unsigned CSUM_MAX_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAY  = 2'd1,
    TRL  = 2'd2
  } frame_state_e;

  // Frame checksum: running sum of payload words modulo 2^width (width <= 64).
  function automatic logic [CSUM_MAX_W-1:0] csum_add(
    input logic [CSUM_MAX_W-1:0] acc,
    input logic [CSUM_MAX_W-1:0] word,
    input int unsigned           width
  );
    logic [CSUM_MAX_W-1:0] mask;
    mask = (width >= CSUM_MAX_W) ? '1 : ((CSUM_MAX_W'(1) << width) - CSUM_MAX_W'(1));
    return (acc + word) & mask;
  endfunction

endpackage

// File: rtl/fifo_wr_slot.sv
// One-entry output register in front of the FIFO write port, gated by the full flag.
module fifo_wr_slot
  import fifo_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_tag,
  input  logic                  fifo_full,
  output logic                  slot_free,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  out_vld,
  output logic                  tag_wr
);

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_tag;

  assign fifo_wr_en = out_vld & ~fifo_full;
  assign slot_free  = ~out_vld | fifo_wr_en;
  assign fifo_data  = out_data;
  assign tag_wr     = fifo_wr_en & out_tag;

  // A new load may overwrite the word leaving this cycle; otherwise the word holds until written.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_tag  <= 1'b0;
    end else if (load) begin
      out_vld  <= 1'b1;
      out_data <= load_data;
      out_tag  <= load_tag;
    end else if (fifo_wr_en) begin
      out_vld  <= 1'b0;
      out_tag  <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_frame_writer.sv
// Wraps a valid/ready payload stream as header(seq), payload, trailer(checksum) into the write-side FIFO.
module fifo_frame_writer
  import fifo_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_LEN    = DEF_MAX_LEN
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  frame_done,
  output logic                  trunc,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);

  frame_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] seq_q, seq_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_tag;
  logic                  slot_free;
  logic                  out_vld;

  fifo_wr_slot #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slot (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .load_tag   (load_tag),
    .fifo_full  (fifo_full),
    .slot_free  (slot_free),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .out_vld    (out_vld),
    .tag_wr     (frame_done)
  );

  assign busy = (state_q != IDLE) | out_vld;

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      seq_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and slot loads; every step that writes the slot waits for slot_free.
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_data = '0;
    load_tag  = 1'b0;
    s_ready   = 1'b0;
    trunc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_valid && slot_free) begin
          load      = 1'b1;
          load_data = seq_q;
          sum_d     = '0;
          cnt_d     = '0;
          state_d   = PAY;
        end
      end
      PAY: begin
        s_ready = slot_free;
        if (s_valid && slot_free) begin
          load      = 1'b1;
          load_data = s_data;
          sum_d     = DATA_WIDTH'(csum_add(CSUM_MAX_W'(sum_q), CSUM_MAX_W'(s_data), DATA_WIDTH));
          cnt_d     = cnt_q + CNT_W'(1);
          if (s_last || (cnt_q == CNT_LAST)) begin
            state_d = TRL;
            trunc   = ~s_last;
          end
        end
      end
      TRL: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = sum_q;
          load_tag  = 1'b1;
          seq_d     = seq_q + DATA_WIDTH'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Directed bench for fifo_frame_writer with a frame-model scoreboard on the FIFO write port.
module tb_fifo_frame_writer;
  import fifo_frame_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned ML = 4;

  logic          wr_clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;
  logic          fifo_full, fifo_wr_en, frame_done, trunc, busy;
  logic [DW-1:0] fifo_data;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            trunc_seen = 0;
  int            wr_log[$];
  logic [DW-1:0] wq[$];
  bit            lq[$];

  logic [DW-1:0] m_seq, m_sum;
  int unsigned   m_cnt;
  bit            m_open;

  fifo_frame_writer #(
    .DATA_WIDTH (DW),
    .MAX_LEN    (ML)
  ) dut (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .frame_done (frame_done),
    .trunc      (trunc),
    .busy       (busy)
  );

  always #5 wr_clk = ~wr_clk;

  always @(posedge wr_clk) cyc++;

  // Scoreboard: every FIFO write must match the next modelled word.
  always @(negedge wr_clk) begin
    if (!rst) begin
      if (trunc) trunc_seen++;
      if (fifo_wr_en) begin
        wr_log.push_back(cyc);
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_write observed=%02h required=no write", fifo_data);
        end
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          tests++;
          assert (fifo_data === mon_e.data) else begin
            fails++;
            $error("FAIL fifo_data observed=%02h required=%02h", fifo_data, mon_e.data);
          end
          tests++;
          assert (frame_done === mon_e.done) else begin
            fails++;
            $error("FAIL frame_done observed=%b required=%b (word %02h)", frame_done, mon_e.done, mon_e.data);
          end
        end
      end else begin
        tests++;
        assert (frame_done === 1'b0) else begin
          fails++;
          $error("FAIL frame_done_idle observed=%b required=0", frame_done);
        end
      end
    end
  end

  // Reference framer: push header/payload/trailer expectations for one source word.
  function automatic void push_word(input logic [DW-1:0] d, input bit last, output bit tr);
    tr = 1'b0;
    if (!m_open) begin
      exp_q.push_back('{data: m_seq, done: 1'b0});
      m_open = 1'b1;
      m_sum  = '0;
      m_cnt  = 0;
    end
    exp_q.push_back('{data: d, done: 1'b0});
    m_sum = m_sum + d;
    m_cnt++;
    if (last || (m_cnt == ML)) begin
      tr = ~last;
      exp_q.push_back('{data: m_sum, done: 1'b1});
      m_seq  = m_seq + 8'd1;
      m_open = 1'b0;
    end
  endfunction

  task automatic drive_beat(input logic [DW-1:0] d, input bit last, input bit exp_tr);
    bit acc;
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      @(negedge wr_clk);
      acc = s_ready;
      if (acc) begin
        tests++;
        assert (trunc === exp_tr) else begin
          fails++;
          $error("FAIL trunc_on_beat observed=%b required=%b (word %02h)", trunc, exp_tr, d);
        end
      end
      @(posedge wr_clk);
      #1;
      n++;
    end
    tests++;
    assert (acc) else begin
      fails++;
      $error("FAIL beat_timeout observed=not accepted required=accepted (word %02h)", d);
    end
  endtask

  task automatic add(input logic [DW-1:0] d, input bit last);
    wq.push_back(d);
    lq.push_back(last);
  endtask

  task automatic send_q();
    bit tr;
    for (int i = 0; i < wq.size(); i++) begin
      push_word(wq[i], lq[i], tr);
      drive_beat(wq[i], lq[i], tr);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    wq.delete();
    lq.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge wr_clk);
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      @(negedge wr_clk);
      n++;
    end
    tests++;
    assert (exp_q.size() == 0 && busy === 1'b0) else begin
      fails++;
      $error("FAIL drain_%s observed=%0d pending busy=%b required=0 pending busy=0", tag, exp_q.size(), busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    assert ({s_ready, fifo_wr_en, fifo_data, frame_done, trunc, busy} === '0) else begin
      fails++;
      $error("FAIL %s observed=rdy%b wr%b d%02h done%b tr%b busy%b required=all zero",
             tag, s_ready, fifo_wr_en, fifo_data, frame_done, trunc, busy);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    s_data    = '0;
    fifo_full = 1'b0;
    exp_q.delete();
    m_seq  = '0;
    m_sum  = '0;
    m_cnt  = 0;
    m_open = 1'b0;
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    check_reset_outputs("reset_values");
    @(posedge wr_clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=still running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit tr;
    rst = 1'b1;
    do_reset();

    // Single frame 11,22,33 -> 00 11 22 33 66 on consecutive cycles.
    wr_log.delete();
    add(8'h11, 0); add(8'h22, 0); add(8'h33, 1);
    send_q();
    drain("single");
    tests++;
    assert (wr_log.size() == 5 && (wr_log[4] - wr_log[0]) == 4) else begin
      fails++;
      $error("FAIL single_spacing observed=%0d writes required=5 in 5 cycles", wr_log.size());
    end

    // Back-to-back 1-word frames: 00 A5 A5 01 5A 5A with no gap.
    do_reset();
    wr_log.delete();
    add(8'hA5, 1); add(8'h5A, 1);
    send_q();
    drain("b2b");
    tests++;
    assert (wr_log.size() == 6 && (wr_log[5] - wr_log[0]) == 5) else begin
      fails++;
      $error("FAIL b2b_spacing observed=%0d writes required=6 in 6 cycles", wr_log.size());
    end

    // Backpressure: full for 3 cycles mid-payload, slot holds 0x42.
    fork
      begin
        add(8'h41, 0); add(8'h42, 0); add(8'h43, 1);
        send_q();
      end
      begin
        repeat (3) @(posedge wr_clk);
        #1 fifo_full = 1'b1;
        repeat (3) begin
          @(negedge wr_clk);
          tests++;
          assert (fifo_wr_en === 1'b0 && s_ready === 1'b0 && fifo_data === 8'h42) else begin
            fails++;
            $error("FAIL full_hold observed=wr%b rdy%b d%02h required=wr0 rdy0 d42",
                   fifo_wr_en, s_ready, fifo_data);
          end
        end
        @(posedge wr_clk);
        #1 fifo_full = 1'b0;
      end
    join
    drain("backpressure");

    // Reset mid-frame after header and two payload beats.
    push_word(8'h31, 0, tr);
    drive_beat(8'h31, 0, 0);
    drive_beat(8'h32, 0, 0);
    rst     = 1'b1;
    s_valid = 1'b0;
    #1;
    check_reset_outputs("reset_immediate");
    @(negedge wr_clk);
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL pre_reset_words observed=%0d pending required=0", exp_q.size());
    end
    m_seq  = '0;
    m_open = 1'b0;
    @(posedge wr_clk);
    #1 rst = 1'b0;
    add(8'h77, 1);
    send_q();
    drain("after_reset");

    // Truncation at MAX_LEN=4: 01..04 trunc, then 05,06 with last.
    do_reset();
    trunc_seen = 0;
    for (int i = 1; i <= 6; i++) add(8'(i), i == 6);
    send_q();
    drain("trunc");
    tests++;
    assert (trunc_seen == 1) else begin
      fails++;
      $error("FAIL trunc_count observed=%0d required=1", trunc_seen);
    end

    // Checksum wrap: FF + 02 -> 01.
    do_reset();
    add(8'hFF, 0); add(8'h02, 1);
    send_q();
    drain("csum_wrap");

    // Sequence wrap: 257 one-word frames, last header is 00.
    do_reset();
    for (int i = 0; i < 257; i++) add(8'(i * 3), 1);
    send_q();
    drain("seq_wrap");
    tests++;
    assert (m_seq == 8'h01) else begin
      fails++;
      $error("FAIL seq_model observed=%02h required=01", m_seq);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
